// File: rtl/matrix_io_pkg.sv
// Shared definitions for the matrix ASCII serializer: ASCII constants,
// the serializer state encoding and the default matrix dimension limit.
package matrix_io_pkg;

    localparam int MAX_DIM_DEFAULT = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CONV,
        ST_EMIT_H,
        ST_EMIT_T,
        ST_EMIT_O,
        ST_EMIT_SEP,
        ST_EMIT_LF,
        ST_DONE
    } state_e;

endpackage

// File: rtl/matrix_ascii_serializer_bin2bcd8.sv
// Combinational 8-bit binary to three BCD digits (double-dabble).
module bin2bcd8 (
    input  logic [7:0] bin_i,
    output logic [3:0] hun_o,
    output logic [3:0] ten_o,
    output logic [3:0] one_o
);

    logic [19:0] sh;

    // Shift-and-add-3 over all eight input bits.
    always_comb begin
        sh = {12'd0, bin_i};
        for (int unsigned i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        hun_o = sh[19:16];
        ten_o = sh[15:12];
        one_o = sh[11:8];
    end

endmodule

// File: rtl/matrix_ascii_serializer.sv
// Walks a stored matrix row-major, converts each element to decimal ASCII
// and streams it over a valid/ready byte interface (space between elements,
// LF after each row). Optional macro MATRIX_SERIALIZER_PAD_EN replaces
// leading-zero suppression with right-aligned space padding (3 chars/element).
module matrix_ascii_serializer
    import matrix_io_pkg::*;
#(
    parameter int MAX_DIM = MAX_DIM_DEFAULT,
    parameter int DIM_W   = 3,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  rows_q, cols_q, r_q, c_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        elem_q;
    logic [3:0]        hun_q, ten_q, one_q;
    logic [3:0]        bcd_h, bcd_t, bcd_o;
    logic              hs, dims_ok, last_col, last_row;

    bin2bcd8 u_bcd (
        .bin_i (elem_q),
        .hun_o (bcd_h),
        .ten_o (bcd_t),
        .one_o (bcd_o)
    );

    assign hs       = out_valid && out_ready;
    assign dims_ok  = (rows != '0) && (cols != '0) &&
                      (rows <= DIM_W'(MAX_DIM)) && (cols <= DIM_W'(MAX_DIM));
    assign last_col = ({1'b0, c_q} + 1'b1) == {1'b0, cols_q};
    assign last_row = ({1'b0, r_q} + 1'b1) == {1'b0, rows_q};
    assign rd_addr  = addr_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; EMIT states only advance on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = dims_ok ? ST_FETCH : ST_DONE;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_CONV;
            ST_CONV: begin
`ifdef MATRIX_SERIALIZER_PAD_EN
                state_d = ST_EMIT_H;
`else
                if (bcd_h != 4'd0)      state_d = ST_EMIT_H;
                else if (bcd_t != 4'd0) state_d = ST_EMIT_T;
                else                    state_d = ST_EMIT_O;
`endif
            end
            ST_EMIT_H:   if (hs) state_d = ST_EMIT_T;
            ST_EMIT_T:   if (hs) state_d = ST_EMIT_O;
            ST_EMIT_O:   if (hs) state_d = last_col ? ST_EMIT_LF : ST_EMIT_SEP;
            ST_EMIT_SEP: if (hs) state_d = ST_FETCH;
            ST_EMIT_LF:  if (hs) state_d = last_row ? ST_DONE : ST_FETCH;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath: dimension latch, row/column/address counters, element and digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q <= '0;
            cols_q <= '0;
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
            elem_q <= '0;
            hun_q  <= '0;
            ten_q  <= '0;
            one_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    rows_q <= rows;
                    cols_q <= cols;
                    r_q    <= '0;
                    c_q    <= '0;
                    addr_q <= '0;
                end
                ST_WAIT: elem_q <= rd_data;
                ST_CONV: begin
                    hun_q <= bcd_h;
                    ten_q <= bcd_t;
                    one_q <= bcd_o;
                end
                ST_EMIT_SEP: if (hs) begin
                    c_q    <= c_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
                ST_EMIT_LF: if (hs && !last_row) begin
                    r_q    <= r_q + 1'b1;
                    c_q    <= '0;
                    addr_q <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        case (state_q)
            ST_FETCH: rd_en = 1'b1;
            ST_EMIT_H: begin
                out_valid = 1'b1;
                out_data  = (hun_q == 4'd0) ? ASCII_SPACE : (ASCII_ZERO | {4'd0, hun_q});
            end
            ST_EMIT_T: begin
                out_valid = 1'b1;
                out_data  = (hun_q == 4'd0 && ten_q == 4'd0) ? ASCII_SPACE
                                                              : (ASCII_ZERO | {4'd0, ten_q});
            end
            ST_EMIT_O: begin
                out_valid = 1'b1;
                out_data  = ASCII_ZERO | {4'd0, one_q};
            end
            ST_EMIT_SEP: begin
                out_valid = 1'b1;
                out_data  = ASCII_SPACE;
            end
            ST_EMIT_LF: begin
                out_valid = 1'b1;
                out_data  = ASCII_LF;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/matrix_ascii_serializer.md
Name: matrix_ascii_serializer

Overview:
- Upstream feeder of the output formatter. On a start pulse, walks a stored matrix in row-major order and reads each 8-bit unsigned element through a 1-cycle-latency read port.
- Converts each element to decimal ASCII digits, separates elements with space (0x20) and ends each row with LF (0x0A).
- Streams the resulting bytes over a valid/ready byte interface whose data feeds matrix_data of the formatter (or a UART TX front end).

Parameters:
- MAX_DIM, 5, maximum rows and maximum columns supported.
- DIM_W, 3, width of the row/column count inputs; must hold MAX_DIM.
- ADDR_W, 5, element address width; must hold MAX_DIM*MAX_DIM-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  1-cycle pulse, begin printing; ignored while busy.
- rows  input  DIM_W  row count, sampled on accepted start.
- cols  input  DIM_W  column count, sampled on accepted start.
- rd_addr  output  ADDR_W  element address = r*cols + c.
- rd_en  output  1  read strobe; rd_data is valid the cycle after rd_en.
- rd_data  input  8  element value, unsigned 0..255.
- out_data  output  8  ASCII byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- busy  output  1  high from accepted start until done.
- done  output  1  1-cycle pulse after the last LF is accepted.

Behaviour:
- Reset values: state IDLE; rd_addr 0, rd_en 0, out_data 0x00, out_valid 0, busy 0, done 0; row/column counters 0.
- Start handling:
  - start is accepted only in IDLE. rows and cols are latched at that point and busy rises the next cycle.
  - If rows==0, cols==0, or either exceeds MAX_DIM: no bytes are emitted, and done pulses 1 cycle after start.
- States and transitions:
  - IDLE -> FETCH on accepted start.
  - FETCH: rd_en=1 for exactly 1 cycle -> WAIT.
  - WAIT: capture rd_data into the element register -> CONV.
  - CONV: latch bin2bcd result (hundreds, tens, ones) -> first EMIT state.
  - EMIT_H -> EMIT_T -> EMIT_O: each emits digit + 0x30.
  - After EMIT_O: EMIT_SEP if c<cols-1; EMIT_LF otherwise.
  - EMIT_SEP -> FETCH with c+1.
  - EMIT_LF -> FETCH with r+1, c=0; or DONE after the last row.
  - DONE: done=1 for 1 cycle -> IDLE.
- Leading-zero suppression (default):
  - EMIT_H is skipped when hundreds==0.
  - EMIT_T is skipped when hundreds==0 and tens==0.
  - The ones digit is always emitted, so value 0 prints as "0".
- Output handshake:
  - Every EMIT state drives out_valid=1 with stable out_data until out_ready is seen. It advances only on the handshake cycle.
  - out_valid never drops without a handshake.
  - out_ready while out_valid=0 is ignored.
- Throughput: one byte per cycle while out_ready is held high. There are 3 cycles of overhead (FETCH, WAIT, CONV) per element.
- Address arithmetic: rd_addr is maintained incrementally (+1 per element), not by a multiplier. Maximum value is MAX_DIM*MAX_DIM-1.
- start during busy: ignored, with no effect on counters.
- Reset mid-operation: returns immediately to the reset values. No partial byte and no done pulse are produced.

Optional Feature:
- Macro: MATRIX_SERIALIZER_PAD_EN.
- Defined: leading-zero suppression is replaced by right-aligned padding. Each suppressed leading digit is emitted as space (0x20), so every element is exactly 3 characters. Example: 7 prints as "  7".
- Undefined: suppression as described under Behaviour. Variable-width fields.

Decomposition:
- Shared package matrix_io_pkg holds:
  - ASCII constants: ASCII_SPACE=0x20, ASCII_LF=0x0A, ASCII_ZERO=0x30.
  - The state enum.
  - MAX_DIM default.
- Sub-module bin2bcd8: combinational 8-bit binary to 3×4-bit BCD (double-dabble). Registered by the CONV state in the parent.

Test Plan:
- Basic 2×2: rows=2, cols=2, memory {1,2,3,4}, out_ready=1 -> bytes 0x31 0x20 0x32 0x0A 0x33 0x20 0x34 0x0A, then one done pulse.
- Multi-digit: 1×3, memory {0,45,255} -> "0 45 255\n" = 0x30 0x20 0x34 0x35 0x20 0x32 0x35 0x35 0x0A.
  - With MATRIX_SERIALIZER_PAD_EN -> "  0  45 255\n".
- Backpressure: 1×1, value 9, out_ready low for 5 cycles after out_valid rises -> out_data holds 0x39 throughout, 0x0A follows only after acceptance, rd_en asserted exactly once.
- Degenerate: rows=0, cols=3 -> no out_valid, done 1 cycle after start. rows=6 -> same.
- Max size: 5×5, memory addr i = i*10 -> rd_addr sequence 0..24, 5 LFs, row 0 = "0 10 20 30 40\n".
- Reset and start interference:
  - rst asserted mid-element of a 3×3 -> out_valid=0, busy=0 at once. A fresh start then reprints from address 0.
  - start pulsed while busy -> ignored, with no effect on the output.
